// File: rtl/div_if.sv
// div_if: configuration handshake and divided-clock status bundle for div_ctrl.
interface div_if #(parameter int DIV_W = 8);
  logic             en;
  logic             cfg_valid;
  logic [DIV_W-1:0] cfg_div;
  logic             cfg_ready;
  logic             cfg_err;
  logic [DIV_W-1:0] cur_div;
  logic [DIV_W-1:0] cnt;
  logic             clk_out_pos;
  logic             odd;
  logic             div_tick;
  logic             busy;
  modport master (output en, cfg_valid, cfg_div,
                  input cfg_ready, cfg_err, cur_div, cnt, clk_out_pos, odd, div_tick, busy);
  modport slave  (input en, cfg_valid, cfg_div,
                  output cfg_ready, cfg_err, cur_div, cnt, clk_out_pos, odd, div_tick, busy);
endinterface

// File: rtl/div_ctrl.sv
// div_ctrl: programmable clock divider with glitch-free ratio updates at period boundaries.
module div_ctrl #(
  parameter int DIV_W   = 8,
  parameter int DEF_DIV = 3
) (
  input  logic clk,
  input  logic rst,
  div_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  localparam logic [DIV_W-1:0] DEF = DIV_W'(DEF_DIV);
  state_t           state, state_n;
  logic [DIV_W-1:0] cnt, cnt_n, cur_div, div_n, pend_div;
  logic             pend_v, err, clk_pos, clk_n, busy, busy_n, bnd, xfer, good;
  function automatic logic [DIV_W:0] half(input logic [DIV_W-1:0] n);
    return ({1'b0, n} + (DIV_W+1)'(1)) >> 1;
  endfunction
  assign busy            = state != IDLE;
  assign bnd             = busy && cnt == cur_div - DIV_W'(1);
  assign xfer            = bus.cfg_valid && !pend_v;
  assign good            = xfer && bus.cfg_div >= DIV_W'(2);
  assign bus.cfg_ready   = !pend_v;
  assign bus.cfg_err     = err;
  assign bus.cur_div     = cur_div;
  assign bus.cnt         = cnt;
  assign bus.clk_out_pos = clk_pos;
  assign bus.odd         = cur_div[0];
  assign bus.div_tick    = bnd;
  assign bus.busy        = busy;
  always_comb begin
    state_n = state;
    cnt_n   = bnd ? '0 : cnt + DIV_W'(1);
    div_n   = cur_div;
    if (state == IDLE) begin
      state_n = bus.en ? RUN : IDLE;
      cnt_n   = '0;
      div_n   = good ? bus.cfg_div : cur_div;
    end else begin
      state_n = bus.en ? RUN : (state == DRAIN && bnd) ? IDLE : DRAIN;
      // a queued ratio wins; otherwise a ratio offered in the boundary cycle bypasses the slot
      div_n   = !bnd ? cur_div : pend_v ? pend_div : good ? bus.cfg_div : cur_div;
    end
    busy_n = state_n != IDLE;
    clk_n  = busy_n && {1'b0, cnt_n} < half(div_n);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      cur_div  <= DEF;
      pend_v   <= 1'b0;
      pend_div <= '0;
      err      <= 1'b0;
      clk_pos  <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      cur_div <= div_n;
      clk_pos <= clk_n;
      err     <= xfer && !good;
      if (bnd) pend_v <= 1'b0;
      else if (busy && good) begin
        pend_v   <= 1'b1;
        pend_div <= bus.cfg_div;
      end
    end
  end
endmodule

// File: tb/tb_div_ctrl.sv
// tb_div_ctrl: directed vectors feed a scoreboard queue; a negedge monitor pops and compares.
module tb_div_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  div_if #(.DIV_W(8)) bus();
  div_ctrl #(.DIV_W(8), .DEF_DIV(3)) dut (.clk(clk), .rst(rst), .bus(bus));
  typedef struct packed {
    logic [7:0] cnt;
    logic [7:0] div;
    logic odd, ck, tick, busy, rdy, err;
  } obs_t;
  obs_t q[$];
  int tests = 0, fails = 0, row = 0;
  function automatic obs_t mk(input logic [7:0] c, dv, input logic ck, tk, bz, rd, er);
    obs_t o;
    o.cnt = c; o.div = dv; o.odd = dv[0]; o.ck = ck; o.tick = tk; o.busy = bz; o.rdy = rd; o.err = er;
    return o;
  endfunction
  task automatic check(input obs_t e, input string tag);
    obs_t a;
    a.cnt = bus.cnt; a.div = bus.cur_div; a.odd = bus.odd; a.ck = bus.clk_out_pos;
    a.tick = bus.div_tick; a.busy = bus.busy; a.rdy = bus.cfg_ready; a.err = bus.cfg_err;
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got cnt=%0d div=%0d odd=%b clk=%b tick=%b busy=%b rdy=%b err=%b, expected cnt=%0d div=%0d odd=%b clk=%b tick=%b busy=%b rdy=%b err=%b",
               tag, a.cnt, a.div, a.odd, a.ck, a.tick, a.busy, a.rdy, a.err,
               e.cnt, e.div, e.odd, e.ck, e.tick, e.busy, e.rdy, e.err);
    end
  endtask
  initial forever begin
    @(negedge clk);
    if (q.size() > 0) begin
      check(q.pop_front(), $sformatf("row%0d", row));
      row++;
    end
  end
  // row: expected outputs this cycle, then inputs driven for the next edge
  task automatic s(input logic e, v, input logic [7:0] d, input logic [7:0] c, dv,
                   input logic ck, tk, bz, rd, er);
    @(posedge clk); #1;
    q.push_back(mk(c, dv, ck, tk, bz, rd, er));
    bus.en = e; bus.cfg_valid = v; bus.cfg_div = d;
  endtask
  initial begin
    bus.en = 1'b0; bus.cfg_valid = 1'b0; bus.cfg_div = 8'd0;
    @(posedge clk); #1;
    q.push_back(mk(8'd0, 8'd3, 0, 0, 0, 1, 0));
    @(negedge clk); #1;
    rst = 1'b0;
    //  en v  d      cnt   div     ck tk bz rd er
    s(1, 0, 8'd0,   8'd0, 8'd3,   0, 0, 0, 1, 0);
    s(1, 0, 8'd0,   8'd0, 8'd3,   1, 0, 1, 1, 0);
    s(1, 0, 8'd0,   8'd1, 8'd3,   1, 0, 1, 1, 0);
    s(1, 0, 8'd0,   8'd2, 8'd3,   0, 1, 1, 1, 0);
    s(1, 1, 8'd4,   8'd0, 8'd3,   1, 0, 1, 1, 0);
    s(1, 0, 8'd0,   8'd1, 8'd3,   1, 0, 1, 0, 0);
    s(1, 0, 8'd0,   8'd2, 8'd3,   0, 1, 1, 0, 0);
    s(1, 0, 8'd0,   8'd0, 8'd4,   1, 0, 1, 1, 0);
    s(1, 0, 8'd0,   8'd1, 8'd4,   1, 0, 1, 1, 0);
    s(1, 0, 8'd0,   8'd2, 8'd4,   0, 0, 1, 1, 0);
    s(1, 1, 8'd3,   8'd3, 8'd4,   0, 1, 1, 1, 0);
    s(1, 0, 8'd0,   8'd0, 8'd3,   1, 0, 1, 1, 0);
    s(1, 0, 8'd0,   8'd1, 8'd3,   1, 0, 1, 1, 0);
    s(1, 1, 8'd5,   8'd2, 8'd3,   0, 1, 1, 1, 0);
    s(1, 1, 8'd1,   8'd0, 8'd5,   1, 0, 1, 1, 0);
    s(1, 1, 8'd0,   8'd1, 8'd5,   1, 0, 1, 1, 1);
    s(1, 0, 8'd0,   8'd2, 8'd5,   1, 0, 1, 1, 1);
    s(1, 0, 8'd0,   8'd3, 8'd5,   0, 0, 1, 1, 0);
    s(1, 0, 8'd0,   8'd4, 8'd5,   0, 1, 1, 1, 0);
    s(1, 0, 8'd0,   8'd0, 8'd5,   1, 0, 1, 1, 0);
    s(0, 0, 8'd0,   8'd1, 8'd5,   1, 0, 1, 1, 0);
    s(0, 0, 8'd0,   8'd2, 8'd5,   1, 0, 1, 1, 0);
    s(0, 0, 8'd0,   8'd3, 8'd5,   0, 0, 1, 1, 0);
    s(0, 0, 8'd0,   8'd4, 8'd5,   0, 1, 1, 1, 0);
    s(0, 1, 8'd7,   8'd0, 8'd5,   0, 0, 0, 1, 0);
    s(1, 0, 8'd0,   8'd0, 8'd7,   0, 0, 0, 1, 0);
    s(1, 0, 8'd0,   8'd0, 8'd7,   1, 0, 1, 1, 0);
    s(0, 0, 8'd0,   8'd1, 8'd7,   1, 0, 1, 1, 0);
    s(0, 0, 8'd0,   8'd2, 8'd7,   1, 0, 1, 1, 0);
    s(1, 0, 8'd0,   8'd3, 8'd7,   1, 0, 1, 1, 0);
    s(1, 0, 8'd0,   8'd4, 8'd7,   0, 0, 1, 1, 0);
    s(1, 0, 8'd0,   8'd5, 8'd7,   0, 0, 1, 1, 0);
    s(1, 0, 8'd0,   8'd6, 8'd7,   0, 1, 1, 1, 0);
    s(1, 0, 8'd0,   8'd0, 8'd7,   1, 0, 1, 1, 0);
    s(1, 1, 8'd9,   8'd1, 8'd7,   1, 0, 1, 1, 0);
    s(1, 0, 8'd0,   8'd2, 8'd7,   1, 0, 1, 0, 0);
    @(negedge clk); #1;
    rst = 1'b1; bus.en = 1'b0; bus.cfg_valid = 1'b0;
    #1 check(mk(8'd0, 8'd3, 0, 0, 0, 1, 0), "async_rst");
    @(posedge clk); #1;
    rst = 1'b0;
    s(1, 0, 8'd0,   8'd0, 8'd3,   0, 0, 0, 1, 0);
    s(1, 0, 8'd0,   8'd0, 8'd3,   1, 0, 1, 1, 0);
    s(1, 0, 8'd0,   8'd1, 8'd3,   1, 0, 1, 1, 0);
    s(0, 0, 8'd0,   8'd2, 8'd3,   0, 1, 1, 1, 0);
    s(0, 0, 8'd0,   8'd0, 8'd3,   1, 0, 1, 1, 0);
    s(0, 0, 8'd0,   8'd1, 8'd3,   1, 0, 1, 1, 0);
    s(0, 0, 8'd0,   8'd2, 8'd3,   0, 1, 1, 1, 0);
    s(0, 1, 8'd255, 8'd0, 8'd3,   0, 0, 0, 1, 0);
    s(1, 0, 8'd0,   8'd0, 8'd255, 0, 0, 0, 1, 0);
    for (int i = 0; i < 256; i++) begin
      int k;
      k = i % 255;
      s(1, 0, 8'd0, 8'(k), 8'd255, k < 128, k == 254, 1, 1, 0);
    end
    for (int i = 0; i < 4 && q.size() > 0; i++) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain: got %0d entries left in scoreboard, expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
